// File: rtl/pq_arbiter.sv
// pq_arbiter: round-robin arbiter/sequencer sharing one max-priority queue among NUM_REQ requesters.
// Latency: accept in T, queue strobe in T+1, settle in T+2, response pulse in T+3; one command per 4 cycles.
// Backpressure: o_req_ready is asserted only in IDLE; responses have no backpressure (one-cycle pulse).
// Ports: i_req_* (valid/op/data per requester) in, o_req_ready one-hot grant out,
//        o_rsp_* tagged response out, o_q_* / i_q_* connect straight to the queue instance.
module pq_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 16,
   parameter int  ENQ_ENA    = 1,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          i_CLK,
   input  logic                          i_RST,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [2*NUM_REQ-1:0]          i_req_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_rsp_valid,
   output logic [ID_W-1:0]               o_rsp_id,
   output logic [DATA_WIDTH-1:0]         o_rsp_data,
   output logic [1:0]                    o_rsp_status,
   output logic                          o_busy,
   output logic                          o_q_wrt,
   output logic                          o_q_read,
   output logic [DATA_WIDTH-1:0]         o_q_data,
   input  logic                          i_q_full,
   input  logic                          i_q_empty,
   input  logic [DATA_WIDTH-1:0]         i_q_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

   localparam logic [1:0] OP_ENQ     = 2'b01;
   localparam logic [1:0] OP_DEQ     = 2'b10;
   localparam logic [1:0] OP_REPL    = 2'b11;
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_FULL    = 2'b01;
   localparam logic [1:0] ST_EMPTY   = 2'b10;
   localparam logic [1:0] ST_ILLEGAL = 2'b11;

   state_t                state_q;
   logic [ID_W-1:0]       rr_q;
   logic [ID_W-1:0]       id_q;
   logic [1:0]            op_q;
   logic [DATA_WIDTH-1:0] key_q;
   logic                  rsp_valid_q;
   logic [1:0]            rsp_status_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;

   // Circular search for the first valid requester starting at rr_q.
   logic                  gnt_vld;
   logic [ID_W-1:0]       gnt_id;
   logic [ID_W-1:0]       cand;
   logic [ID_W-1:0]       rr_d;
   logic [1:0]            gnt_op;
   logic [DATA_WIDTH-1:0] gnt_key;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
         if (!gnt_vld && i_req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   always_comb begin
      gnt_op  = '0;
      gnt_key = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (gnt_id == ID_W'(r)) begin
            gnt_op  = i_req_op[2*r +: 2];
            gnt_key = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Explicit wrap so non-power-of-two NUM_REQ rotates correctly.
   assign rr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

   always_comb begin
      o_req_ready = '0;
      if (state_q == S_IDLE && gnt_vld) o_req_ready[gnt_id] = 1'b1;
   end

   // Action decided from the queue flags as they stand during ISSUE.
   logic                  dec_wrt;
   logic                  dec_rd;
   logic [1:0]            dec_status;
   logic [DATA_WIDTH-1:0] dec_data;

   always_comb begin
      dec_wrt    = 1'b0;
      dec_rd     = 1'b0;
      dec_status = ST_OK;
      dec_data   = '0;
      case (op_q)
         OP_ENQ: begin
            if (ENQ_ENA == 0)  dec_status = ST_ILLEGAL;
            else if (i_q_full) dec_status = ST_FULL;
            else               dec_wrt    = 1'b1;
         end
         OP_DEQ: begin
            if (i_q_empty) begin
               dec_status = ST_EMPTY;
            end else begin
               dec_rd   = 1'b1;
               dec_data = i_q_data;
            end
         end
         OP_REPL: begin
            // Replace is legal when full or with enqueue disabled; head goes back as old max.
            dec_wrt = 1'b1;
            dec_rd  = 1'b1;
            if (!i_q_empty) dec_data = i_q_data;
         end
         default: dec_status = ST_ILLEGAL;
      endcase
   end

   // Strobes are gated by the registered ISSUE state so they are confined to that
   // single cycle, yet still reflect the flags seen in ISSUE; reset removes them at once.
   assign o_q_wrt      = (state_q == S_ISSUE) && dec_wrt;
   assign o_q_read     = (state_q == S_ISSUE) && dec_rd;
   assign o_q_data     = key_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_id     = id_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_status = rsp_status_q;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q      <= S_IDLE;
         rr_q         <= '0;
         id_q         <= '0;
         op_q         <= '0;
         key_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= '0;
         rsp_data_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               rsp_valid_q <= 1'b0;
               if (gnt_vld) begin
                  op_q    <= gnt_op;
                  key_q   <= gnt_key;
                  id_q    <= gnt_id;
                  rr_q    <= rr_d;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rsp_status_q <= dec_status;
               rsp_data_q   <= dec_data;
               state_q      <= S_SETTLE;
            end
            S_SETTLE: begin
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            default: begin
               rsp_valid_q  <= 1'b0;
               rsp_status_q <= '0;
               rsp_data_q   <= '0;
               key_q        <= '0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pq_arbiter.sv
// Bench for pq_arbiter: the bench plays the queue (sorted list) and a transaction-level
// reference that predicts grant, strobes and responses every cycle.
module tb_pq_arbiter;
   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int CAP = 128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [2*N-1:0]  req_op;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic [1:0]      rsp_id_o;
   logic [DW-1:0]   rsp_data_o;
   logic [1:0]      rsp_status_o;
   logic            busy, q_wrt, q_read;
   logic [DW-1:0]   q_data_o;
   logic            q_full, q_empty;
   logic [DW-1:0]   q_head;

   pq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ENQ_ENA(1)) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_req_valid(req_valid), .i_req_op(req_op), .i_req_data(req_data),
      .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id_o), .o_rsp_data(rsp_data_o),
      .o_rsp_status(rsp_status_o), .o_busy(busy),
      .o_q_wrt(q_wrt), .o_q_read(q_read), .o_q_data(q_data_o),
      .i_q_full(q_full), .i_q_empty(q_empty), .i_q_data(q_head)
   );

   // Second build with enqueue disabled.
   logic [N-1:0]    e_valid;
   logic [2*N-1:0]  e_op;
   logic [N*DW-1:0] e_data;
   logic [N-1:0]    e_ready;
   logic            e_rsp_valid, e_busy, e_wrt, e_read;
   logic [1:0]      e_rsp_id, e_rsp_status;
   logic [DW-1:0]   e_rsp_data, e_q_data;
   logic            e_full, e_empty;
   logic [DW-1:0]   e_head;

   pq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ENQ_ENA(0)) dut_noenq (
      .i_CLK(clk), .i_RST(rst),
      .i_req_valid(e_valid), .i_req_op(e_op), .i_req_data(e_data),
      .o_req_ready(e_ready),
      .o_rsp_valid(e_rsp_valid), .o_rsp_id(e_rsp_id), .o_rsp_data(e_rsp_data),
      .o_rsp_status(e_rsp_status), .o_busy(e_busy),
      .o_q_wrt(e_wrt), .o_q_read(e_read), .o_q_data(e_q_data),
      .i_q_full(e_full), .i_q_empty(e_empty), .i_q_data(e_head)
   );

   // Reference state: ph counts cycles since accept (0 = idle).
   int mq[$];
   int ph, rr, cyc;
   int cur_id, cur_op, cur_key;
   int d_wrt, d_rd, d_status, d_data;
   bit v[N];  int vop[N]; int vdat[N];
   bit vd[N]; int dop[N]; int ddat[N];
   bit rand_mode;
   int n_chk, n_fail;
   int acc_cyc[$], acc_id[$], rsp_cyc[$], rsp_id[$], rsp_st[$], rsp_dt[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int grant();
      for (int k = 0; k < N; k++) begin
         if (vd[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic decide();
      d_wrt = 0; d_rd = 0; d_status = 0; d_data = 0;
      case (cur_op)
         1: begin
            if (mq.size() >= CAP) d_status = 1;
            else d_wrt = 1;
         end
         2: begin
            if (mq.size() == 0) d_status = 2;
            else begin d_rd = 1; d_data = mq[0]; end
         end
         3: begin
            d_wrt = 1; d_rd = 1;
            d_data = (mq.size() != 0) ? mq[0] : 0;
         end
         default: d_status = 3;
      endcase
   endtask

   task automatic q_apply();
      if (d_wrt != 0 && d_rd != 0) begin
         if (mq.size() == 0) mq.push_back(cur_key);
         else mq[0] = cur_key;
      end else if (d_wrt != 0) mq.push_back(cur_key);
      else if (d_rd != 0) void'(mq.pop_front());
      mq.rsort();
   endtask

   task automatic rand_reqs();
      for (int r = 0; r < N; r++) begin
         if (!v[r]) begin
            if ($urandom_range(0, 3) == 0) begin
               int x;
               x = $urandom_range(0, 19);
               vop[r]  = (x < 8) ? 1 : (x < 15) ? 2 : (x < 19) ? 3 : 0;
               vdat[r] = $urandom_range(0, 65535);
               v[r]    = 1'b1;
            end
         end else if ($urandom_range(0, 29) == 0) begin
            v[r] = 1'b0;  // withdraw before grant
         end
      end
   endtask

   task automatic tick();
      int g;
      int exp_ready;
      @(posedge clk);
      #1;
      cyc++;
      // Advance the reference across the edge just taken, using the inputs live at it.
      case (ph)
         0: begin
            g = grant();
            if (g >= 0) begin
               cur_id = g; cur_op = dop[g]; cur_key = ddat[g];
               rr = (g + 1) % N; v[g] = 1'b0; ph = 1;
            end
         end
         1: begin q_apply(); ph = 2; end
         2: ph = 3;
         default: ph = 0;
      endcase
      if (rand_mode) rand_reqs();
      for (int r = 0; r < N; r++) begin
         vd[r] = v[r]; dop[r] = vop[r]; ddat[r] = vdat[r];
         req_valid[r]         = v[r];
         req_op[2*r +: 2]     = 2'(vop[r]);
         req_data[r*DW +: DW] = DW'(vdat[r]);
      end
      q_full  = (mq.size() >= CAP);
      q_empty = (mq.size() == 0);
      q_head  = (mq.size() != 0) ? DW'(mq[0]) : '0;
      #1;
      g = (ph == 0) ? grant() : -1;
      exp_ready = (g >= 0) ? (1 << g) : 0;
      if (ph == 1) decide();
      check("ready", int'(req_ready), exp_ready);
      check("busy", int'(busy), (ph != 0) ? 1 : 0);
      check("q_wrt", int'(q_wrt), (ph == 1) ? d_wrt : 0);
      check("q_read", int'(q_read), (ph == 1) ? d_rd : 0);
      check("q_data", int'(q_data_o), (ph != 0) ? cur_key : 0);
      check("rsp_valid", int'(rsp_valid), (ph == 3) ? 1 : 0);
      if (ph == 3 && rsp_valid) begin
         check("rsp_id", int'(rsp_id_o), cur_id);
         check("rsp_status", int'(rsp_status_o), d_status);
         check("rsp_data", int'(rsp_data_o), d_data);
      end
      for (int r = 0; r < N; r++) begin
         if (req_ready[r]) begin acc_id.push_back(r); acc_cyc.push_back(cyc); end
      end
      if (rsp_valid) begin
         rsp_cyc.push_back(cyc); rsp_id.push_back(int'(rsp_id_o));
         rsp_st.push_back(int'(rsp_status_o)); rsp_dt.push_back(int'(rsp_data_o));
      end
   endtask

   task automatic wait_rsp(input int n);
      int start;
      start = rsp_id.size();
      for (int i = 0; i < 12 * n + 20 && rsp_id.size() < start + n; i++) tick();
      check("rsp_count", rsp_id.size() - start, n);
   endtask

   task automatic send(input int r, input int op, input int key);
      v[r] = 1'b1; vop[r] = op; vdat[r] = key;
      wait_rsp(1);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; ph = 0; rr = 0; rand_mode = 1'b0;
      for (int r = 0; r < N; r++) begin
         v[r] = 0; vop[r] = 0; vdat[r] = 0; vd[r] = 0; dop[r] = 0; ddat[r] = 0;
      end
      req_valid = '0; req_op = '0; req_data = '0;
      q_full = 1'b0; q_empty = 1'b1; q_head = '0;
      e_valid = '0; e_op = '0; e_data = '0; e_full = 1'b0; e_empty = 1'b1; e_head = '0;
      rst = 1'b1;
      #2;
      check("reset_ready", int'(req_ready), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_strobes", int'({q_wrt, q_read}), 0);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_q_data", int'(q_data_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // ENQ 100 from requester 0 after reset.
      send(0, 1, 100);
      check("t1_id", rsp_id[$], 0);
      check("t1_status", rsp_st[$], 0);
      check("t1_data", rsp_dt[$], 0);
      check("t1_latency", rsp_cyc[$] - acc_cyc[$], 3);

      // DEQ on an empty queue.
      mq.delete();
      send(2, 2, 0);
      check("t2_status", rsp_st[$], 2);
      check("t2_data", rsp_dt[$], 0);

      // REPL 50 on {500,300}, then DEQ.
      mq.delete(); mq.push_back(500); mq.push_back(300);
      send(1, 3, 50);
      check("t3_repl_status", rsp_st[$], 0);
      check("t3_repl_data", rsp_dt[$], 500);
      send(3, 2, 0);
      check("t3_deq_data", rsp_dt[$], 300);

      // Four simultaneous ENQs starting from pointer 0.
      for (int r = 0; r < N; r++) begin v[r] = 1'b1; vop[r] = 1; vdat[r] = 11 * (r + 1); end
      wait_rsp(4);
      for (int i = 0; i < N; i++) check("t4_order", acc_id[acc_id.size() - N + i], i);
      for (int i = 1; i < N; i++)
         check("t4_spacing", acc_cyc[acc_cyc.size() - N + i] - acc_cyc[acc_cyc.size() - N + i - 1], 4);
      check("t4_rr", rr, 0);

      // Full queue and illegal opcode.
      mq.delete();
      for (int i = 0; i < CAP; i++) mq.push_back(1000 + i);
      mq.rsort();
      send(0, 1, 5);
      check("t5_full", rsp_st[$], 1);
      send(2, 0, 7);
      check("t5_illegal", rsp_st[$], 3);
      mq.delete();

      // Reset during ISSUE of a DEQ.
      mq.push_back(9); mq.push_back(7); mq.rsort();
      v[1] = 1'b1; vop[1] = 2; vdat[1] = 0;
      for (int i = 0; i < 20 && ph != 1; i++) tick();
      check("t6_reach_issue", ph, 1);
      check("t6_read_high", int'(q_read), 1);
      #1 rst = 1'b1;
      #1;
      check("t6_read_cut", int'(q_read), 0);
      check("t6_busy_cut", int'(busy), 0);
      ph = 0; rr = 0;
      for (int r = 0; r < N; r++) begin v[r] = 0; vd[r] = 0; end
      req_valid = '0;
      @(posedge clk);
      #3 rst = 1'b0;
      for (int r = 0; r < N; r++) begin v[r] = 1'b1; vop[r] = 1; vdat[r] = 200 + r; end
      tick();
      check("t6_first_grant", int'(req_ready), 1);
      wait_rsp(4);

      // Randomised traffic.
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) tick();
      rand_mode = 1'b0;
      for (int r = 0; r < N; r++) v[r] = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // Enqueue-disabled build: ENQ is rejected without a strobe.
      @(posedge clk); #1;
      e_valid = 4'b0010; e_op = 8'b0000_0100; e_data = {16'd0, 16'd0, 16'd77, 16'd0};
      #1 check("noenq_ready", int'(e_ready), 2);
      @(posedge clk); #1;
      e_valid = '0;
      #1 check("noenq_no_wrt", int'({e_wrt, e_read}), 0);
      check("noenq_busy", int'(e_busy), 1);
      @(posedge clk); @(posedge clk); #2;
      check("noenq_rsp_valid", int'(e_rsp_valid), 1);
      check("noenq_status", int'(e_rsp_status), 3);
      check("noenq_id", int'(e_rsp_id), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
